dist_coe_loader: RTL and testbench

//  Writer side of the distance-coefficient SRAM table that dist_calculate reads (bilinear lookup).
//  - Takes a byte stream from the host packet parser (W5500 path) and packs it into big-endian 16-bit words.
//  - Writes each word to SRAM at BASE_ADDR + word index through a req/ack write port.
//  - Checks a 16-bit additive checksum and reports done or error.

---
 rtl/dist_coe_pkg.sv | 48 ++++
 rtl/dist_coe_loader_if.sv | 57 +++++
 rtl/dist_coe_loader.sv | 188 ++++++++++++++++++
 tb/tb_dist_coe_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_coe_pkg.sv
// ============================================================================
//  Package     : dist_coe_pkg
//  Description : Shared constants for the distance-coefficient SRAM table.
//                Used by the table writer (dist_coe_loader) and the bilinear
//                reader (dist_calculate) so both agree on the table base
//                address, capacity and index geometry.
//  Contents    : table geometry, error codes, loader state encoding and a
//                load-length validity helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dist_coe_pkg;

  // Table placement and geometry: 256 pulse rows x 512 rise columns.
  localparam logic [17:0] COE_BASE_ADDR   = 18'h10000;
  localparam logic [17:0] COE_TABLE_WORDS = 18'h20000;
  localparam int          COE_PULSE_SHIFT = 7;
  localparam int          COE_RISE_SHIFT  = 6;
  localparam int          COE_ROW_SHIFT   = 9;

  // Clocks the writer waits for an SRAM write acknowledge.
  localparam logic [15:0] COE_ACK_TIMEOUT = 16'd1000;

  // Sticky load error codes.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_SUM  = 2'b11;

  // One-hot loader states, matching the rest of the distance path.
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_RECV_HI = 5'b00010,
    ST_RECV_LO = 5'b00100,
    ST_WRITE   = 5'b01000,
    ST_CHECK   = 5'b10000
  } coe_ld_state_e;

  // A load length is usable when it is non-zero and fits in the table.
  function automatic logic coe_len_ok(input logic [17:0] len,
                                      input logic [17:0] max_words);
    return (len != 18'd0) && (len <= max_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dist_coe_loader_if.sv
// ============================================================================
//  Interface   : dist_coe_loader_if
//  Description : Control, byte-stream, SRAM write port and status signals of
//                the coefficient table loader. Signal names carry their
//                direction as seen from the loader.
//  Modports    : master - host side (parser / arbiter / supervisor)
//                slave  - dist_coe_loader
//  Signals     : i_load_start/i_load_len/i_expect_sum/i_load_abort  control
//                i_byte_data/i_byte_valid/o_byte_ready                stream
//                o_sram_wr_req/i_sram_wr_ack/o_sram_addr/o_sram_data  SRAM
//                o_busy/o_load_done/o_load_err/o_word_cnt             status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dist_coe_loader_if;

  logic        i_load_start;
  logic [17:0] i_load_len;
  logic [15:0] i_expect_sum;
  logic        i_load_abort;

  logic [7:0]  i_byte_data;
  logic        i_byte_valid;
  logic        o_byte_ready;

  logic        o_sram_wr_req;
  logic        i_sram_wr_ack;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_data;

  logic        o_busy;
  logic        o_load_done;
  logic [1:0]  o_load_err;
  logic [17:0] o_word_cnt;

  modport master (
    output i_load_start, i_load_len, i_expect_sum, i_load_abort,
    output i_byte_data, i_byte_valid,
    input  o_byte_ready,
    input  o_sram_wr_req, o_sram_addr, o_sram_data,
    output i_sram_wr_ack,
    input  o_busy, o_load_done, o_load_err, o_word_cnt
  );

  modport slave (
    input  i_load_start, i_load_len, i_expect_sum, i_load_abort,
    input  i_byte_data, i_byte_valid,
    output o_byte_ready,
    output o_sram_wr_req, o_sram_addr, o_sram_data,
    input  i_sram_wr_ack,
    output o_busy, o_load_done, o_load_err, o_word_cnt
  );

endinterface

`default_nettype wire

// File: rtl/dist_coe_loader.sv
// ============================================================================
//  Module      : dist_coe_loader
//  Description : Writer side of the distance-coefficient SRAM table. Packs a
//                host byte stream into big-endian 16-bit words, writes word n
//                to BASE_ADDR + n through a req/ack port, and verifies a
//                mod-2^16 additive checksum at the end of the load.
//  Ports       : i_clk_50m  system clock
//                i_rst_n    asynchronous active-low reset
//                bus        dist_coe_loader_if.slave (control, byte stream,
//                           SRAM write port, sticky status)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dist_coe_loader
  import dist_coe_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR   = COE_BASE_ADDR,
  parameter logic [17:0] MAX_WORDS   = COE_TABLE_WORDS,
  parameter logic [15:0] ACK_TIMEOUT = COE_ACK_TIMEOUT
) (
  input  logic             i_clk_50m,
  input  logic             i_rst_n,
  dist_coe_loader_if.slave bus
);

  // Last timer value before the write is abandoned; the request is then
  // held for exactly ACK_TIMEOUT clocks.
  localparam logic [15:0] C_TMO_LAST = 16'(ACK_TIMEOUT - 16'd1);

  coe_ld_state_e state_q, state_d;
  logic [7:0]    hi_q,     hi_d;
  logic [15:0]   word_q,   word_d;
  logic [15:0]   sum_q,    sum_d;
  logic [17:0]   cnt_q,    cnt_d;
  logic [17:0]   len_q,    len_d;
  logic [15:0]   expect_q, expect_d;
  logic [15:0]   timer_q,  timer_d;
  logic          done_q,   done_d;
  logic [1:0]    err_q,    err_d;

  logic          w_recv;
  logic          w_byte_ready;
  logic          w_accept;
  logic          w_wr_req;
  logic [17:0]   w_cnt_inc;

  // Abort wins over a byte offered in the same cycle, so the byte is not
  // reported as consumed.
  assign w_recv       = (state_q == ST_RECV_HI) || (state_q == ST_RECV_LO);
  assign w_byte_ready = w_recv && !bus.i_load_abort;
  assign w_accept     = w_byte_ready && bus.i_byte_valid;
  assign w_wr_req     = (state_q == ST_WRITE);
  assign w_cnt_inc    = 18'(cnt_q + 18'd1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      word_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      expect_q <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      word_q   <= word_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      expect_q <= expect_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    word_d   = word_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    expect_d = expect_q;
    timer_d  = timer_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_load_start) begin
          done_d = 1'b0;
          if (!coe_len_ok(bus.i_load_len, MAX_WORDS)) begin
            err_d = ERR_LEN;
          end else begin
            err_d    = ERR_NONE;
            cnt_d    = '0;
            sum_d    = '0;
            len_d    = bus.i_load_len;
            expect_d = bus.i_expect_sum;
            state_d  = ST_RECV_HI;
          end
        end
      end

      ST_RECV_HI: begin
        if (bus.i_load_abort) begin
          err_d   = ERR_SUM;
          state_d = ST_IDLE;
        end else if (w_accept) begin
          hi_d    = bus.i_byte_data;
          state_d = ST_RECV_LO;
        end
      end

      ST_RECV_LO: begin
        if (bus.i_load_abort) begin
          err_d   = ERR_SUM;
          state_d = ST_IDLE;
        end else if (w_accept) begin
          word_d  = {hi_q, bus.i_byte_data};
          timer_d = '0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Ack is tested before the timer so an ack on the expiry cycle
        // still completes the write.
        if (bus.i_load_abort) begin
          err_d   = ERR_SUM;
          state_d = ST_IDLE;
        end else if (bus.i_sram_wr_ack) begin
          sum_d   = 16'(sum_q + word_q);
          cnt_d   = w_cnt_inc;
          state_d = (w_cnt_inc == len_q) ? ST_CHECK : ST_RECV_HI;
        end else if (timer_q == C_TMO_LAST) begin
          err_d   = ERR_TMO;
          state_d = ST_IDLE;
        end else begin
          timer_d = 16'(timer_q + 16'd1);
        end
      end

      ST_CHECK: begin
        if (bus.i_load_abort) begin
          err_d = ERR_SUM;
        end else if (sum_q == expect_q) begin
          done_d = 1'b1;
        end else begin
          err_d = ERR_SUM;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Address and data are forced to zero outside WRITE so the port
  // is quiet whenever no request is pending.
  // --------------------------------------------------------------------------
  assign bus.o_byte_ready  = w_byte_ready;
  assign bus.o_sram_wr_req = w_wr_req;
  assign bus.o_sram_addr   = w_wr_req ? 18'(BASE_ADDR + cnt_q) : 18'd0;
  assign bus.o_sram_data   = w_wr_req ? word_q : 16'd0;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_load_done   = done_q;
  assign bus.o_load_err    = err_q;
  assign bus.o_word_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dist_coe_loader.sv
// ============================================================================
//  Module      : tb_dist_coe_loader
//  Description : Self-checking bench for dist_coe_loader. A byte driver and an
//                acknowledging SRAM model run beside the stimulus; expected
//                writes and end-of-load status are queued when a load is
//                issued and consumed by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dist_coe_loader;
  import dist_coe_pkg::*;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        done;
    logic [1:0]  err;
    logic [17:0] cnt;
  } st_t;

  logic clk = 1'b0;
  logic rst_n;

  dist_coe_loader_if bus();

  dist_coe_loader dut (
    .i_clk_50m (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passes = 0;

  wr_t        exp_wr_q[$];
  st_t        exp_st_q[$];
  logic [7:0] tx_q[$];
  logic [15:0] words_q[$];

  bit rand_valid = 1'b0;
  bit ack_en     = 1'b1;
  int ack_min    = 0;
  int ack_max    = 0;
  int last_run   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic flag(input string name, input string msg);
    checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // --------------------------------------------------------------------------
  // Byte stream driver: offers the head of tx_q, optionally with random gaps,
  // and pops it only after a cycle in which valid and ready were both high.
  // --------------------------------------------------------------------------
  initial begin
    bit took;
    took = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (took && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0 && (!rand_valid || $urandom_range(1, 0) == 1)) begin
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data  = tx_q[0];
      end else begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte_data  = 8'($urandom);
      end
      #2;
      took = bus.i_byte_valid && bus.o_byte_ready;
    end
  end

  // --------------------------------------------------------------------------
  // SRAM arbiter model: acknowledges a pending request after a random delay.
  // --------------------------------------------------------------------------
  initial begin
    int wait_n;
    int dly;
    wait_n = 0;
    dly    = 0;
    bus.i_sram_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.i_sram_wr_ack) begin
        bus.i_sram_wr_ack = 1'b0;
      end else if (bus.o_sram_wr_req && ack_en) begin
        if (wait_n >= dly) begin
          bus.i_sram_wr_ack = 1'b1;
          wait_n = 0;
          dly    = $urandom_range(ack_max, ack_min);
        end else begin
          wait_n++;
        end
      end else if (!bus.o_sram_wr_req) begin
        wait_n = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples just after inputs settle, well before the next edge.
  // --------------------------------------------------------------------------
  initial begin
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_busy = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    int          run       = 0;
    wr_t         w;
    st_t         s;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0; prev_ack = 1'b0; prev_busy = 1'b0; run = 0;
        continue;
      end
      if (bus.o_sram_wr_req) begin
        chk("ready_low_in_write", 32'(bus.o_byte_ready), 32'd0);
        if (prev_req && !prev_ack) begin
          chk("addr_stable", 32'(bus.o_sram_addr), 32'(prev_addr));
          chk("data_stable", 32'(bus.o_sram_data), 32'(prev_data));
        end
        run++;
        if (bus.i_sram_wr_ack) begin
          if (exp_wr_q.size() == 0) begin
            flag("unexpected_write", $sformatf("addr 0x%0h data 0x%0h", bus.o_sram_addr, bus.o_sram_data));
          end else begin
            w = exp_wr_q.pop_front();
            chk("wr_addr", 32'(bus.o_sram_addr), 32'(w.addr));
            chk("wr_data", 32'(bus.o_sram_data), 32'(w.data));
          end
          run = 0;
        end
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (prev_busy && !bus.o_busy) begin
        if (exp_st_q.size() == 0) begin
          flag("unexpected_load_end", $sformatf("err %0d cnt %0d", bus.o_load_err, bus.o_word_cnt));
        end else begin
          s = exp_st_q.pop_front();
          chk("load_done", 32'(bus.o_load_done), 32'(s.done));
          chk("load_err",  32'(bus.o_load_err),  32'(s.err));
          chk("word_cnt",  32'(bus.o_word_cnt),  32'(s.cnt));
        end
      end
      prev_req  = bus.o_sram_wr_req;
      prev_ack  = bus.i_sram_wr_ack;
      prev_busy = bus.o_busy;
      prev_addr = bus.o_sram_addr;
      prev_data = bus.o_sram_data;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic pulse_start(input logic [17:0] len, input logic [15:0] sum);
    @(negedge clk);
    bus.i_load_start = 1'b1;
    bus.i_load_len   = len;
    bus.i_expect_sum = sum;
    @(negedge clk);
    bus.i_load_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    bus.i_load_abort = 1'b1;
    @(negedge clk);
    bus.i_load_abort = 1'b0;
  endtask

  task automatic push_bytes(input logic [15:0] w);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) flag("idle_timeout", $sformatf("still busy after %0d clocks", budget));
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [15:0] model_sum();
    logic [15:0] s = 16'h0000;
    foreach (words_q[i]) s = 16'(s + words_q[i]);
    return s;
  endfunction

  // Full load of words_q: the reference says every word lands at
  // base + index and the load passes exactly when the sums agree.
  task automatic run_load(input logic [15:0] expect_sum, input bit rnd, input int amin, input int amax);
    logic [15:0] s;
    s = model_sum();
    foreach (words_q[i]) exp_wr_q.push_back('{addr: 18'(COE_BASE_ADDR + 18'(i)), data: words_q[i]});
    exp_st_q.push_back('{done: (s == expect_sum),
                         err:  (s == expect_sum) ? ERR_NONE : ERR_SUM,
                         cnt:  18'(words_q.size())});
    rand_valid = rnd;
    ack_min    = amin;
    ack_max    = amax;
    ack_en     = 1'b1;
    pulse_start(18'(words_q.size()), expect_sum);
    foreach (words_q[i]) push_bytes(words_q[i]);
    wait_idle(5000);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    bus.i_load_start = 1'b0;
    bus.i_load_len   = '0;
    bus.i_expect_sum = '0;
    bus.i_load_abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_busy",  32'(bus.o_busy),        32'd0);
    chk("rst_done",  32'(bus.o_load_done),   32'd0);
    chk("rst_err",   32'(bus.o_load_err),    32'd0);
    chk("rst_cnt",   32'(bus.o_word_cnt),    32'd0);
    chk("rst_req",   32'(bus.o_sram_wr_req), 32'd0);
    chk("rst_ready", 32'(bus.o_byte_ready),  32'd0);
    chk("rst_addr",  32'(bus.o_sram_addr),   32'd0);
    chk("rst_data",  32'(bus.o_sram_data),   32'd0);

    // Basic load, fixed ack latency.
    words_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0000};
    run_load(model_sum(), 1'b0, 2, 2);

    // Length bounds: zero and one past capacity are rejected at once.
    pulse_start(18'd0, 16'h0000);
    #2;
    chk("len0_err",  32'(bus.o_load_err),    32'(ERR_LEN));
    chk("len0_busy", 32'(bus.o_busy),        32'd0);
    chk("len0_req",  32'(bus.o_sram_wr_req), 32'd0);
    pulse_start(18'h20001, 16'h0000);
    #2;
    chk("lenmax1_err",  32'(bus.o_load_err), 32'd1);
    chk("lenmax1_busy", 32'(bus.o_busy),     32'd0);
    // Exactly full capacity is accepted; abort it before any data.
    exp_st_q.push_back('{done: 1'b0, err: ERR_SUM, cnt: 18'd0});
    pulse_start(18'h20000, 16'h0000);
    #2;
    chk("lenmax_busy", 32'(bus.o_busy), 32'd1);
    pulse_abort();
    wait_idle(100);

    // No ack ever: request held for the full timeout, nothing counted.
    ack_en = 1'b0;
    exp_st_q.push_back('{done: 1'b0, err: ERR_TMO, cnt: 18'd0});
    rand_valid = 1'b0;
    pulse_start(18'd2, 16'h0000);
    push_bytes(16'hABCD);
    push_bytes(16'h1234);
    wait_idle(5000);
    tx_q.delete();
    repeat (3) @(negedge clk);
    chk("tmo_req_clocks", 32'(last_run), 32'(COE_ACK_TIMEOUT));
    ack_en = 1'b1;

    // Wrong expected sum: both words still written.
    words_q = '{16'h1000, 16'h0234};
    run_load(16'h0000, 1'b0, 0, 0);

    // Randomized loads with gappy valid and ack delay 0..5.
    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(9, 1);
      words_q.delete();
      for (int i = 0; i < len; i++) words_q.push_back(16'($urandom));
      if (k % 3 == 2) run_load(16'(model_sum() ^ 16'(1 << (k % 16))), 1'b1, 0, 5);
      else            run_load(model_sum(), 1'b1, 0, 5);
    end

    // Abort during the second write; a start issued mid-load must be ignored.
    rand_valid = 1'b0;
    ack_min = 1; ack_max = 1; ack_en = 1'b1;
    exp_wr_q.push_back('{addr: COE_BASE_ADDR, data: 16'h1111});
    exp_st_q.push_back('{done: 1'b0, err: ERR_SUM, cnt: 18'd1});
    pulse_start(18'd3, 16'h0000);
    push_bytes(16'h1111);
    n = 0;
    while (bus.o_word_cnt != 18'd1 && n < 200) begin @(negedge clk); n++; end
    if (bus.o_word_cnt != 18'd1) flag("first_word_timeout", "first word never acknowledged");
    ack_en = 1'b0;
    pulse_start(18'd5, 16'h5555);
    push_bytes(16'h2222);
    n = 0;
    while (!bus.o_sram_wr_req && n < 200) begin @(negedge clk); n++; end
    if (!bus.o_sram_wr_req) flag("second_req_timeout", "second write never requested");
    repeat (3) @(negedge clk);
    pulse_abort();
    #2;
    chk("abort_req",  32'(bus.o_sram_wr_req), 32'd0);
    chk("abort_busy", 32'(bus.o_busy),        32'd0);
    chk("abort_cnt",  32'(bus.o_word_cnt),    32'd1);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);

    chk("writes_outstanding", 32'(exp_wr_q.size()), 32'd0);
    chk("status_outstanding", 32'(exp_st_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
